// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA frame read scheduler.
// Holds the FSM state encoding and the buffer index type.
package vga_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WAIT,
    S_REQ,
    S_BUSY,
    S_DONE
  } state_e;

  typedef logic [1:0] buf_idx_t;

  localparam int NUM_BUFS        = 3;
  localparam int BURST_LEN_DFLT  = 64;
  localparam int BEAT_BYTES_DFLT = 8;
  localparam int BURST_BYTES     =
    BURST_LEN_DFLT * BEAT_BYTES_DFLT;

  // Byte span of one burst for a given beat count and beat size
  function automatic int burst_bytes(
    input int len,
    input int beat
  );
    return len * beat;
  endfunction

endpackage

// File: rtl/frame_buf_rotator.sv
// Triple-buffer bookkeeping: newest completed buffer,
// display selection with same-cycle bypass, writer target.
module frame_buf_rotator
  import vga_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_frame_done,
  input  buf_idx_t wr_buf_idx,
  input  buf_idx_t disp_buf_idx,
  output buf_idx_t sel_idx,
  output logic     sel_valid,
  output buf_idx_t wr_buf_sel
);

  buf_idx_t last_idx_q;
  buf_idx_t last_idx_d;
  logic     last_valid_q;
  logic     last_valid_d;
  buf_idx_t wr_buf_sel_q;
  buf_idx_t wr_buf_sel_d;

  // Remember the buffer the writer most recently finished
  always_comb begin
    last_idx_d   = last_idx_q;
    last_valid_d = last_valid_q;
    if (wr_frame_done) begin
      last_idx_d   = wr_buf_idx;
      last_valid_d = 1'b1;
    end
  end

  // A completion in this very cycle wins over the stored index
  always_comb begin
    sel_idx   = wr_frame_done ? wr_buf_idx : last_idx_q;
    sel_valid = wr_frame_done | last_valid_q;
  end

  // Lowest buffer that is neither on screen nor the newest frame
  always_comb begin
    wr_buf_sel_d = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if ((buf_idx_t'(i) != disp_buf_idx) &&
          !(last_valid_q &&
            (buf_idx_t'(i) == last_idx_q)))
        wr_buf_sel_d = buf_idx_t'(i);
    end
  end

  // Bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
      wr_buf_sel_q <= 2'd1;
    end else begin
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
      wr_buf_sel_q <= wr_buf_sel_d;
    end
  end

  assign wr_buf_sel = wr_buf_sel_q;

endmodule

// File: rtl/vga_frame_rd_sched.sv
// Refills the display FIFO from DDR3 with fixed-size bursts,
// restarting on each frame start at the selected buffer.
module vga_frame_rd_sched
  import vga_sched_pkg::*;
#(
  parameter int          ADDR_W       = 30,
  parameter int          BEAT_BYTES   = 8,
  parameter int          BURST_LEN    = 64,
  parameter int          FRAME_BEATS  = 614400,
  parameter logic [31:0] FRAME_BASE   = 32'h0,
  parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000,
  parameter int          FIFO_DEPTH   = 1024,
  parameter int          LEVEL_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               wr_frame_done,
  input  logic [1:0]         wr_buf_idx,
  input  logic [LEVEL_W-1:0] rd_fifo_level,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_ack,
  input  logic               rd_done,
  output logic               fifo_flush,
  output logic [1:0]         disp_buf_idx,
  output logic [1:0]         wr_buf_sel,
  output logic               frame_active,
  output logic               underrun
);

  localparam int STEP_B = burst_bytes(BURST_LEN, BEAT_BYTES);
  localparam int BEAT_W = $clog2(FRAME_BEATS + 1);

  localparam logic [LEVEL_W-1:0] LVL_THR =
    LEVEL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [BEAT_W-1:0] BEATS_INIT =
    BEAT_W'(FRAME_BEATS);
  localparam logic [BEAT_W-1:0] BEATS_STEP =
    BEAT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_STEP =
    ADDR_W'(STEP_B);
  localparam logic [ADDR_W-1:0] BASE_A =
    ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A =
    ADDR_W'(FRAME_STRIDE);

  state_e              state_q;
  state_e              state_d;
  logic                vsync_q;
  logic                frame_start;
  logic [BEAT_W-1:0]   beats_left_q;
  logic [BEAT_W-1:0]   beats_left_d;
  logic [BEAT_W-1:0]   beats_next;
  logic                last_burst;
  logic                lvl_ok;
  logic                restart_pend_q;
  logic                restart_pend_d;
  logic                restart;
  logic                rd_req_q;
  logic                rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                fifo_flush_q;
  logic                fifo_flush_d;
  buf_idx_t            disp_q;
  buf_idx_t            disp_d;
  logic                frame_active_q;
  logic                frame_active_d;
  logic                underrun_q;
  logic                underrun_d;
  buf_idx_t            sel_idx;
  logic                sel_valid;

  frame_buf_rotator u_rot (
    .clk           (clk),
    .rst           (rst),
    .wr_frame_done (wr_frame_done),
    .wr_buf_idx    (wr_buf_idx),
    .disp_buf_idx  (disp_q),
    .sel_idx       (sel_idx),
    .sel_valid     (sel_valid),
    .wr_buf_sel    (wr_buf_sel)
  );

  // Shared conditions for both FSM processes
  always_comb begin
    frame_start = vsync_in & ~vsync_q;
    lvl_ok      = rd_fifo_level <= LVL_THR;
    beats_next  = beats_left_q - BEATS_STEP;
    last_burst  = beats_next == '0;
    restart     = restart_pend_q | frame_start;
  end

  // State register and vsync edge delay
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_in;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (frame_start && sel_valid)
          state_d = S_FLUSH;
      S_FLUSH:
        state_d = S_WAIT;
      S_WAIT:
        if (frame_start)
          state_d = S_FLUSH;
        else if (lvl_ok)
          state_d = S_REQ;
      S_REQ:
        if (rd_ack)
          state_d = S_BUSY;
      S_BUSY:
        if (rd_done) begin
          if (restart)
            state_d = S_FLUSH;
          else if (last_burst)
            state_d = S_DONE;
          else
            state_d = S_WAIT;
        end
      S_DONE:
        if (frame_start)
          state_d = S_FLUSH;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Registered outputs, counters and restart bookkeeping
  always_comb begin
    rd_req_d       = rd_req_q;
    rd_addr_d      = rd_addr_q;
    disp_d         = disp_q;
    beats_left_d   = beats_left_q;
    frame_active_d = frame_active_q;
    restart_pend_d = restart_pend_q;
    fifo_flush_d   = state_d == S_FLUSH;
    underrun_d     = 1'b0;
    case (state_q)
      S_FLUSH: begin
        disp_d         = sel_idx;
        rd_addr_d      = BASE_A +
                         STRIDE_A * ADDR_W'(sel_idx);
        beats_left_d   = BEATS_INIT;
        frame_active_d = 1'b1;
        restart_pend_d = 1'b0;
      end
      S_WAIT: begin
        if (frame_start)
          underrun_d = 1'b1;
        else if (lvl_ok)
          rd_req_d = 1'b1;
      end
      S_REQ: begin
        if (frame_start && !restart_pend_q) begin
          underrun_d     = 1'b1;
          restart_pend_d = 1'b1;
        end
        if (rd_ack) begin
          rd_req_d  = 1'b0;
          rd_addr_d = rd_addr_q + ADDR_STEP;
        end
      end
      S_BUSY: begin
        if (frame_start && !restart_pend_q) begin
          underrun_d     = 1'b1;
          restart_pend_d = 1'b1;
        end
        if (rd_done) begin
          beats_left_d = beats_next;
          if (!restart && last_burst)
            frame_active_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_q       <= 1'b0;
      rd_addr_q      <= '0;
      fifo_flush_q   <= 1'b0;
      disp_q         <= '0;
      frame_active_q <= 1'b0;
      underrun_q     <= 1'b0;
      beats_left_q   <= '0;
      restart_pend_q <= 1'b0;
    end else begin
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      fifo_flush_q   <= fifo_flush_d;
      disp_q         <= disp_d;
      frame_active_q <= frame_active_d;
      underrun_q     <= underrun_d;
      beats_left_q   <= beats_left_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign fifo_flush   = fifo_flush_q;
  assign disp_buf_idx = disp_q;
  assign frame_active = frame_active_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_vga_frame_rd_sched.sv
// Bench for vga_frame_rd_sched: DDR responder plus
// address scoreboard and frame-level checks.
module tb_vga_frame_rd_sched;
  import vga_sched_pkg::*;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync_in = 1'b0;
  logic          wr_frame_done = 1'b0;
  logic [1:0]    wr_buf_idx = 2'd0;
  logic [10:0]   rd_fifo_level = 11'd0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack = 1'b0;
  logic          rd_done = 1'b0;
  logic          fifo_flush;
  logic [1:0]    disp_buf_idx;
  logic [1:0]    wr_buf_sel;
  logic          frame_active;
  logic          underrun;

  int n_chk = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int flush_cnt = 0;
  int urun_cnt = 0;
  int req_cyc = 0;
  int ack_wait = 0;
  int dcnt = 0;
  int rq = 0;
  int b_ack, b_done, b_fl, b_ur, b_req;
  int drops, n;
  logic [31:0] exp_addr[$];

  always #5 clk = ~clk;

  vga_frame_rd_sched #(
    .ADDR_W       (AW),
    .BEAT_BYTES   (8),
    .BURST_LEN    (64),
    .FRAME_BEATS  (256),
    .FRAME_BASE   (32'h0),
    .FRAME_STRIDE (32'h1000),
    .FIFO_DEPTH   (256),
    .LEVEL_W      (11)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vsync_in      (vsync_in),
    .wr_frame_done (wr_frame_done),
    .wr_buf_idx    (wr_buf_idx),
    .rd_fifo_level (rd_fifo_level),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_done       (rd_done),
    .fifo_flush    (fifo_flush),
    .disp_buf_idx  (disp_buf_idx),
    .wr_buf_sel    (wr_buf_sel),
    .frame_active  (frame_active),
    .underrun      (underrun)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h exp 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fa(
    input logic  val,
    input string tag
  );
    int k = 0;
    while (frame_active !== val && k < 400) begin
      tick();
      k++;
    end
    chk(tag, 32'(frame_active), 32'(val));
  endtask

  task automatic wait_acks(
    input int    target,
    input string tag
  );
    int k = 0;
    while (ack_cnt < target && k < 400) begin
      tick();
      k++;
    end
    chk(tag, 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] base);
    for (int i = 0; i < 4; i++)
      exp_addr.push_back(base + 32'(i) * 32'h200);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_flush"}, 32'(fifo_flush), 32'd0);
    chk({tag, "_disp"}, 32'(disp_buf_idx), 32'd0);
    chk({tag, "_wsel"}, 32'(wr_buf_sel), 32'd1);
    chk({tag, "_fa"}, 32'(frame_active), 32'd0);
    chk({tag, "_ur"}, 32'(underrun), 32'd0);
    chk({tag, "_st"}, 32'(dut.state_q), 32'(S_IDLE));
  endtask

  // DDR responder: ack after a programmable wait, done 4 later
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rd_ack  = 1'b0;
      rd_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          rd_done = 1'b1;
          done_cnt++;
        end
      end else if (rd_req === 1'b1) begin
        rq++;
        if (rq > ack_wait) begin
          rd_ack = 1'b1;
          ack_cnt++;
          rq   = 0;
          dcnt = 4;
          chk("sb_nonempty",
              32'(exp_addr.size() > 0), 32'd1);
          if (exp_addr.size() > 0)
            chk("rd_addr", 32'(rd_addr),
                exp_addr.pop_front());
        end else if (exp_addr.size() > 0) begin
          chk("addr_hold", 32'(rd_addr), exp_addr[0]);
        end
      end
    end
  end

  // Event counters sampled mid-cycle
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (fifo_flush === 1'b1) flush_cnt++;
      if (underrun === 1'b1)   urun_cnt++;
      if (rd_req === 1'b1)     req_cyc++;
    end
  end

  initial begin
    repeat (3) tick();
    chk_reset_vals("rst0");
    rst = 1'b0;
    tick();

    // no writer frame yet: vsync does nothing
    b_req = req_cyc;
    b_fl  = flush_cnt;
    repeat (2) begin
      vs_pulse();
      repeat (3) tick();
    end
    chk("t1_req", 32'(req_cyc - b_req), 32'd0);
    chk("t1_flush", 32'(flush_cnt - b_fl), 32'd0);
    chk("t1_st", 32'(dut.state_q), 32'(S_IDLE));
    chk("t1_wsel", 32'(wr_buf_sel), 32'd1);

    // writer finishes buffer 1, then one full frame
    wr_buf_idx    = 2'd1;
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    repeat (2) tick();
    chk("t2_wsel_pre", 32'(wr_buf_sel), 32'd2);
    b_fl   = flush_cnt;
    b_ur   = urun_cnt;
    b_ack  = ack_cnt;
    b_done = done_cnt;
    push_frame(32'h1000);
    vs_pulse();
    wait_fa(1'b1, "t2_fa_rise");
    wait_fa(1'b0, "t2_fa_fall");
    chk("t2_done_at_fall", 32'(done_cnt - b_done), 32'd4);
    repeat (2) tick();
    chk("t2_flush", 32'(flush_cnt - b_fl), 32'd1);
    chk("t2_disp", 32'(disp_buf_idx), 32'd1);
    chk("t2_acks", 32'(ack_cnt - b_ack), 32'd4);
    chk("t2_sb_left", 32'(exp_addr.size()), 32'd0);
    chk("t2_wsel", 32'(wr_buf_sel), 32'd0);
    chk("t2_ur", 32'(urun_cnt - b_ur), 32'd0);
    chk("t2_st", 32'(dut.state_q), 32'(S_DONE));

    // FIFO level threshold and a slow ack
    rd_fifo_level = 11'd193;
    push_frame(32'h1000);
    vs_pulse();
    repeat (8) tick();
    chk("t3_no_req", 32'(rd_req), 32'd0);
    chk("t3_st", 32'(dut.state_q), 32'(S_WAIT));
    ack_wait      = 10;
    rd_fifo_level = 11'd192;
    tick();
    chk("t3_req_rise", 32'(rd_req), 32'd1);
    drops = 0;
    repeat (9) begin
      tick();
      if (rd_req !== 1'b1) drops++;
    end
    chk("t3_req_hold", 32'(drops), 32'd0);
    ack_wait      = 0;
    rd_fifo_level = 11'd0;
    wait_fa(1'b0, "t3_fa_fall");
    chk("t3_sb_left", 32'(exp_addr.size()), 32'd0);

    // frame start while a burst is in flight
    tick();
    b_fl  = flush_cnt;
    b_ur  = urun_cnt;
    b_ack = ack_cnt;
    exp_addr.push_back(32'h1000);
    exp_addr.push_back(32'h1200);
    vs_pulse();
    wait_acks(b_ack + 2, "t4_ack2");
    push_frame(32'h1000);
    vs_pulse();
    tick();
    vs_pulse();
    n = 0;
    while (flush_cnt - b_fl < 2 && n < 400) begin
      tick();
      n++;
    end
    chk("t4_reflush", 32'(flush_cnt - b_fl), 32'd2);
    chk("t4_no_req", 32'(ack_cnt - b_ack), 32'd2);
    chk("t4_ur", 32'(urun_cnt - b_ur), 32'd1);
    wait_fa(1'b0, "t4_fa_fall");
    chk("t4_acks", 32'(ack_cnt - b_ack), 32'd6);
    chk("t4_sb_left", 32'(exp_addr.size()), 32'd0);

    // writer completion coincident with frame start
    tick();
    b_ack = ack_cnt;
    push_frame(32'h2000);
    vsync_in      = 1'b1;
    wr_frame_done = 1'b1;
    wr_buf_idx    = 2'd2;
    tick();
    vsync_in      = 1'b0;
    wr_frame_done = 1'b0;
    wait_fa(1'b1, "t5_fa_rise");
    wait_fa(1'b0, "t5_fa_fall");
    repeat (2) tick();
    chk("t5_disp", 32'(disp_buf_idx), 32'd2);
    chk("t5_wsel", 32'(wr_buf_sel), 32'd0);
    chk("t5_acks", 32'(ack_cnt - b_ack), 32'd4);
    chk("t5_sb_left", 32'(exp_addr.size()), 32'd0);

    // reset while a burst is outstanding
    b_ack = ack_cnt;
    exp_addr.push_back(32'h2000);
    vs_pulse();
    wait_acks(b_ack + 1, "t6_ack");
    tick();
    chk("t6_busy", 32'(dut.state_q), 32'(S_BUSY));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("t6");
    exp_addr.delete();
    b_done = done_cnt;
    b_fl   = flush_cnt;
    b_req  = req_cyc;
    repeat (6) tick();
    chk("t6_done_seen", 32'(done_cnt - b_done), 32'd1);
    chk("t6_st", 32'(dut.state_q), 32'(S_IDLE));
    chk("t6_req", 32'(req_cyc - b_req), 32'd0);
    chk("t6_flush", 32'(flush_cnt - b_fl), 32'd0);
    chk("t6_fa", 32'(frame_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
